// File: rtl/bus_pkg.sv
// Shared constants and helpers for the bus arbiter slice.
// Mode encodings and a request popcount used for contention detection.
package bus_pkg;

    localparam int MODE_WIRED_OR    = 0;
    localparam int MODE_ROUND_ROBIN = 1;
    localparam int MAX_SOURCES      = 16;

    // Number of set bits in a request vector (zero-extended to MAX_SOURCES).
    function automatic logic [4:0] popcount(input logic [MAX_SOURCES-1:0] i_vec);
        logic [4:0] w_sum;
        w_sum = 5'd0;
        for (int i = 0; i < MAX_SOURCES; i++) begin
            w_sum = w_sum + {4'd0, i_vec[i]};
        end
        return w_sum;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first request at or above the pointer,
// wrapping to the lowest request when none lie above it. Output is one-hot.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_SOURCES = 6,
    parameter int PTR_WIDTH   = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] i_req,
    input  logic [PTR_WIDTH-1:0]   i_ptr,
    output logic [NUM_SOURCES-1:0] o_grant
);

    logic [NUM_SOURCES-1:0] w_at_or_above;
    logic [NUM_SOURCES-1:0] w_upper;
    logic [NUM_SOURCES-1:0] w_pick;

    // Lowest set bit of the preferred window isolates the winner.
    always_comb begin
        w_at_or_above = '0;
        for (int s = 0; s < NUM_SOURCES; s++) begin
            w_at_or_above[s] = (PTR_WIDTH'(s) >= i_ptr);
        end
        w_upper = i_req & w_at_or_above;
        w_pick  = (|w_upper) ? w_upper : i_req;
        o_grant = w_pick & (~w_pick + NUM_SOURCES'(1));
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: legacy wired-OR merging with contention tracking, or
// round-robin single-owner arbitration with optional lock. All outputs registered.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_SOURCES = 6,
    parameter logic [NUM_SOURCES*BUS_WIDTH-1:0] LANE_MASK = '1,
    parameter int MODE        = MODE_WIRED_OR,
    parameter int HOLD_EN     = 0,
    parameter int CNT_WIDTH   = 8,
    localparam int OWN_WIDTH  = $clog2(NUM_SOURCES)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_SOURCES-1:0]           i_req,
    input  logic [NUM_SOURCES*BUS_WIDTH-1:0] i_data,
    input  logic                             i_lock,
    input  logic                             i_clear_err,
    output logic [NUM_SOURCES-1:0]           o_grant,
    output logic [OWN_WIDTH-1:0]             o_owner,
    output logic [BUS_WIDTH-1:0]             o_bus_data,
    output logic                             o_bus_valid,
    output logic                             o_contention,
    output logic [CNT_WIDTH-1:0]             o_contention_count
);

    logic [BUS_WIDTH-1:0]   w_masked [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] w_rr_grant;
    logic [NUM_SOURCES-1:0] w_lock_grant;
    logic [NUM_SOURCES-1:0] w_grant_next;
    logic [OWN_WIDTH-1:0]   w_owner_next;
    logic [OWN_WIDTH-1:0]   w_ptr_next;
    logic [BUS_WIDTH-1:0]   w_or_data;
    logic [BUS_WIDTH-1:0]   w_bus_next;
    logic                   w_any_req;
    logic                   w_lock_hit;
    logic                   w_contend;
    logic                   w_cont_next;
    logic [CNT_WIDTH-1:0]   w_cnt_next;

    logic [NUM_SOURCES-1:0] r_grant;
    logic [OWN_WIDTH-1:0]   r_owner;
    logic [OWN_WIDTH-1:0]   r_ptr;
    logic [BUS_WIDTH-1:0]   r_bus_data;
    logic                   r_bus_valid;
    logic                   r_contention;
    logic [CNT_WIDTH-1:0]   r_cnt;

    rr_arbiter #(
        .NUM_SOURCES (NUM_SOURCES),
        .PTR_WIDTH   (OWN_WIDTH)
    ) u_rr_arbiter (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant)
    );

    // Per-source data restricted to the lanes that source may drive.
    always_comb begin
        for (int s = 0; s < NUM_SOURCES; s++) begin
            w_masked[s] = i_data[s*BUS_WIDTH +: BUS_WIDTH] & LANE_MASK[s*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    // Grant selection, owner index, merged bus value and pointer advance.
    always_comb begin
        w_any_req    = |i_req;
        w_lock_hit   = i_lock && r_bus_valid && i_req[r_owner];
        w_lock_grant = '0;
        w_lock_grant[r_owner] = 1'b1;
        if (MODE == MODE_ROUND_ROBIN) begin
            w_grant_next = w_lock_hit ? w_lock_grant : w_rr_grant;
        end else begin
            w_grant_next = i_req;
        end

        // Descending scan so the lowest granted index ends up as owner.
        w_owner_next = '0;
        w_or_data    = '0;
        for (int s = NUM_SOURCES - 1; s >= 0; s--) begin
            w_owner_next = w_grant_next[s] ? OWN_WIDTH'(s) : w_owner_next;
            w_or_data    = w_or_data | (w_masked[s] & {BUS_WIDTH{w_grant_next[s]}});
        end

        if (w_any_req) begin
            w_bus_next = w_or_data;
        end else if (HOLD_EN != 0) begin
            w_bus_next = r_bus_data;
        end else begin
            w_bus_next = '0;
        end

        if ((MODE == MODE_ROUND_ROBIN) && w_any_req && !w_lock_hit) begin
            w_ptr_next = (w_owner_next == OWN_WIDTH'(NUM_SOURCES - 1)) ? '0
                                                                        : w_owner_next + OWN_WIDTH'(1);
        end else begin
            w_ptr_next = r_ptr;
        end
    end

    // Contention flag and saturating counter; a new contention beats a clear.
    always_comb begin
        w_contend = (MODE == MODE_WIRED_OR) && (popcount(MAX_SOURCES'(i_req)) >= 5'd2);
        if (w_contend) begin
            w_cont_next = 1'b1;
            if (i_clear_err) begin
                w_cnt_next = CNT_WIDTH'(1);
            end else if (r_cnt == '1) begin
                w_cnt_next = r_cnt;
            end else begin
                w_cnt_next = r_cnt + CNT_WIDTH'(1);
            end
        end else if (i_clear_err) begin
            w_cont_next = 1'b0;
            w_cnt_next  = '0;
        end else begin
            w_cont_next = r_contention;
            w_cnt_next  = r_cnt;
        end
    end

    // Output and pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant      <= '0;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_bus_data   <= '0;
            r_bus_valid  <= 1'b0;
            r_contention <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_grant      <= w_grant_next;
            r_owner      <= w_owner_next;
            r_ptr        <= w_ptr_next;
            r_bus_data   <= w_bus_next;
            r_bus_valid  <= w_any_req;
            r_contention <= w_cont_next;
            r_cnt        <= w_cnt_next;
        end
    end

    assign o_grant            = r_grant;
    assign o_owner            = r_owner;
    assign o_bus_data         = r_bus_data;
    assign o_bus_valid        = r_bus_valid;
    assign o_contention       = r_contention;
    assign o_contention_count = r_cnt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: a wired-OR instance (hold on, source 5 lanes 0x0F) and a
// round-robin instance share stimulus; reference models queue expected outputs.
module tb_bus_arbiter;

    localparam logic [47:0] MASK_A = {8'h0F, 40'hFF_FFFF_FFFF};

    typedef struct packed {
        logic [5:0] grant;
        logic [2:0] owner;
        logic [7:0] data;
        logic       valid;
        logic       cont;
        logic [7:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  i_req;
    logic [47:0] i_data;
    logic        i_lock;
    logic        i_clear_err;

    logic [5:0] grant_a, grant_b;
    logic [2:0] owner_a, owner_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       cont_a, cont_b;
    logic [7:0] cnt_a, cnt_b;

    exp_t qa[$];
    exp_t qb[$];

    int n_vec = 0;
    int n_err = 0;

    // wired-OR model state
    logic [7:0] ma_data;
    logic       ma_cont;
    int         ma_cnt;
    // round-robin model state
    int         mb_ptr;
    int         mb_owner;
    logic       mb_valid;

    bus_arbiter #(
        .BUS_WIDTH(8), .NUM_SOURCES(6), .LANE_MASK(MASK_A),
        .MODE(0), .HOLD_EN(1), .CNT_WIDTH(8)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_data(i_data),
        .i_lock(i_lock), .i_clear_err(i_clear_err),
        .o_grant(grant_a), .o_owner(owner_a), .o_bus_data(data_a),
        .o_bus_valid(valid_a), .o_contention(cont_a), .o_contention_count(cnt_a)
    );

    bus_arbiter #(
        .BUS_WIDTH(8), .NUM_SOURCES(6), .LANE_MASK({48{1'b1}}),
        .MODE(1), .HOLD_EN(0), .CNT_WIDTH(8)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_data(i_data),
        .i_lock(i_lock), .i_clear_err(i_clear_err),
        .o_grant(grant_b), .o_owner(owner_b), .o_bus_data(data_b),
        .o_bus_valid(valid_b), .o_contention(cont_b), .o_contention_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input exp_t act, input exp_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got grant=%b owner=%0d data=%h valid=%b cont=%b cnt=%0d, want grant=%b owner=%0d data=%h valid=%b cont=%b cnt=%0d",
                     nm, $time, act.grant, act.owner, act.data, act.valid, act.cont, act.cnt,
                     exp.grant, exp.owner, exp.data, exp.valid, exp.cont, exp.cnt);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared just after the edge.
    always @(posedge clk) begin
        exp_t act;
        #1;
        if (qa.size() > 0) begin
            act = {grant_a, owner_a, data_a, valid_a, cont_a, cnt_a};
            cmp("wired_or", act, qa.pop_front());
        end
        if (qb.size() > 0) begin
            act = {grant_b, owner_b, data_b, valid_b, cont_b, cnt_b};
            cmp("round_robin", act, qb.pop_front());
        end
    end

    task automatic reset_models();
        ma_data  = 8'h00;
        ma_cont  = 1'b0;
        ma_cnt   = 0;
        mb_ptr   = 0;
        mb_owner = 0;
        mb_valid = 1'b0;
    endtask

    // Drive one cycle of stimulus and enqueue the expected registered response.
    task automatic apply(input logic [5:0] req_v, input logic [47:0] data_v,
                         input logic lock_v, input logic clr_v);
        exp_t       ea;
        exp_t       eb;
        logic [7:0] acc;
        int         winner;
        int         idx;
        @(negedge clk);
        i_req       = req_v;
        i_data      = data_v;
        i_lock      = lock_v;
        i_clear_err = clr_v;

        acc      = 8'h00;
        ea.owner = 3'd0;
        for (int s = 5; s >= 0; s--) begin
            if (req_v[s]) begin
                acc      = acc | (data_v[s*8 +: 8] & MASK_A[s*8 +: 8]);
                ea.owner = 3'(s);
            end
        end
        if (req_v != 6'd0) ma_data = acc;
        if ($countones(req_v) >= 2) begin
            ma_cont = 1'b1;
            ma_cnt  = clr_v ? 1 : ((ma_cnt < 255) ? ma_cnt + 1 : 255);
        end else if (clr_v) begin
            ma_cont = 1'b0;
            ma_cnt  = 0;
        end
        ea.grant = req_v;
        ea.data  = ma_data;
        ea.valid = |req_v;
        ea.cont  = ma_cont;
        ea.cnt   = 8'(ma_cnt);
        qa.push_back(ea);

        winner = -1;
        if (lock_v && mb_valid && req_v[mb_owner]) begin
            winner = mb_owner;
        end else begin
            for (int k = 0; k < 6; k++) begin
                idx = (mb_ptr + k) % 6;
                if (winner < 0 && req_v[idx]) winner = idx;
            end
            if (winner >= 0) mb_ptr = (winner + 1) % 6;
        end
        mb_valid = (winner >= 0);
        mb_owner = (winner >= 0) ? winner : 0;
        eb.grant = (winner >= 0) ? 6'(1 << winner) : 6'd0;
        eb.owner = 3'(mb_owner);
        eb.data  = (winner >= 0) ? data_v[winner*8 +: 8] : 8'h00;
        eb.valid = mb_valid;
        eb.cont  = 1'b0;
        eb.cnt   = 8'd0;
        qb.push_back(eb);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        i_req       = 6'd0;
        i_data      = 48'd0;
        i_lock      = 1'b0;
        i_clear_err = 1'b0;
        qa.delete();
        qb.delete();
        reset_models();
        #1;
        chk("reset_a", {5'd0, grant_a, owner_a, data_a, valid_a, cont_a, cnt_a}, 32'd0);
        chk("reset_b", {5'd0, grant_b, owner_b, data_b, valid_b, cont_b, cnt_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        i_req       = 6'd0;
        i_data      = 48'd0;
        i_lock      = 1'b0;
        i_clear_err = 1'b0;
        reset_models();
        do_reset();

        // single driver
        apply(6'b000001, 48'h00_00_00_00_00_5A, 1'b0, 1'b0);
        step();
        chk("single_data", {24'd0, data_a}, 32'h5A);
        chk("single_valid", {31'd0, valid_a}, 32'd1);
        chk("single_cont", {31'd0, cont_a}, 32'd0);

        // two drivers merge and count contention until saturation
        apply(6'b000011, 48'h00_00_00_00_0F_F0, 1'b0, 1'b0);
        step();
        chk("merge_data", {24'd0, data_a}, 32'hFF);
        chk("merge_cont", {31'd0, cont_a}, 32'd1);
        chk("merge_cnt1", {24'd0, cnt_a}, 32'd1);
        for (int i = 0; i < 299; i++) apply(6'b000011, 48'h00_00_00_00_0F_F0, 1'b0, 1'b0);
        step();
        chk("cnt_saturate", {24'd0, cnt_a}, 32'd255);

        apply(6'b000001, 48'h00_00_00_00_00_11, 1'b0, 1'b1);
        step();
        chk("clear_cnt", {23'd0, cont_a, cnt_a}, 32'd0);
        apply(6'b000011, 48'h00_00_00_00_22_11, 1'b0, 1'b1);
        step();
        chk("clear_vs_set", {23'd0, cont_a, cnt_a}, {23'd0, 1'b1, 8'd1});

        // idle behaviour: hold vs zero
        apply(6'b010000, 48'h00_33_00_00_00_00, 1'b0, 1'b0);
        apply(6'b000000, 48'h00_00_00_00_00_00, 1'b0, 1'b0);
        step();
        chk("hold_data", {24'd0, data_a}, 32'h33);
        chk("hold_valid", {31'd0, valid_a}, 32'd0);
        chk("nohold_data", {24'd0, data_b}, 32'h00);

        // lane mask, then asynchronous reset mid-grant
        apply(6'b100000, 48'hAB_00_00_00_00_00, 1'b0, 1'b0);
        step();
        chk("lane_mask", {24'd0, data_a}, 32'h0B);
        chk("lane_full_b", {24'd0, data_b}, 32'hAB);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", {5'd0, grant_a, owner_a, data_a, valid_a, cont_a, cnt_a}, 32'd0);
        chk("async_rst_b", {5'd0, grant_b, owner_b, data_b, valid_b, cont_b, cnt_b}, 32'd0);
        do_reset();

        // round-robin rotation from source 0
        apply(6'b101010, 48'h66_55_44_33_22_11, 1'b0, 1'b0);
        step();
        chk("rr_1", {29'd0, owner_b}, 32'd1);
        apply(6'b101010, 48'h66_55_44_33_22_11, 1'b0, 1'b0);
        step();
        chk("rr_3", {29'd0, owner_b}, 32'd3);
        apply(6'b101010, 48'h66_55_44_33_22_11, 1'b0, 1'b0);
        step();
        chk("rr_5", {29'd0, owner_b}, 32'd5);
        apply(6'b101010, 48'h66_55_44_33_22_11, 1'b0, 1'b0);
        step();
        chk("rr_wrap", {29'd0, owner_b}, 32'd1);

        // lock keeps source 2, release falls back to arbitration
        apply(6'b000100, 48'h66_55_44_33_22_11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(6'b000110, 48'h66_55_44_33_22_11, 1'b1, 1'b0);
            step();
            chk("lock_hold", {29'd0, owner_b}, 32'd2);
        end
        apply(6'b000010, 48'h66_55_44_33_22_11, 1'b1, 1'b0);
        step();
        chk("lock_release", {29'd0, owner_b}, 32'd1);

        // randomized traffic against the models
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  r_req;
            logic [47:0] r_dat;
            r_req = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) r_req = 6'd0;
            r_dat = {16'($urandom), 32'($urandom)};
            apply(r_req, r_dat, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        if (qa.size() > 0 || qb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d/%0d expectations left, want 0", qa.size(), qb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BUS_WIDTH, default 8, bus data width in bits.
REQ-002 Parameter NUM_SOURCES, default 6, number of bus drivers (2..16).
REQ-003 Parameter LANE_MASK, NUM_SOURCES*BUS_WIDTH bits, default all ones; slice s gives the bus bits source s is allowed to drive.
REQ-004 Parameter MODE, default 0; 0 = wired-OR (legacy), 1 = round-robin arbitration.
REQ-005 Parameter HOLD_EN, default 0; 1 = bus holds last driven value when idle.
REQ-006 Parameter CNT_WIDTH, default 8, contention counter width.
REQ-007 i_clk  in  1  sole clock, rising edge.
REQ-008 i_rst_n  in  1  asynchronous active-low reset.
REQ-009 i_req  in  NUM_SOURCES  per-source drive request (bit s = source s).
REQ-010 i_data  in  NUM_SOURCES*BUS_WIDTH  per-source data, slice s = source s.
REQ-011 i_lock  in  1  MODE 1: keep current owner while its request stays high.
REQ-012 i_clear_err  in  1  clears contention flag and counter.
REQ-013 o_grant  out  NUM_SOURCES  registered grant, at most one bit set in MODE 1.
REQ-014 o_owner  out  clog2(NUM_SOURCES)  registered index of granted source, 0 when idle.
REQ-015 o_bus_data  out  BUS_WIDTH  registered bus value.
REQ-016 o_bus_valid  out  1  high when o_bus_data carries a driven value this cycle.
REQ-017 o_contention  out  1  sticky multi-driver error flag.
REQ-018 o_contention_count  out  CNT_WIDTH  saturating count of contention cycles.

Function
REQ-019 Latency: request/data sampled at edge N appear on o_bus_data/o_grant/o_bus_valid after edge N, i.e. one cycle.
REQ-020 Masked data of source s = data slice s AND LANE_MASK slice s; unmasked bits contribute 0.
REQ-021 MODE 0: o_grant = i_req registered; o_bus_data = OR of masked data of all requesting sources.
REQ-022 MODE 0: cycle with two or more i_req bits high sets o_contention and increments o_contention_count.
REQ-023 MODE 1: winner = first requesting source at or after pointer, searching upward with wrap from NUM_SOURCES-1 to 0.
REQ-024 MODE 1: after a grant to source w, pointer = (w+1) mod NUM_SOURCES; pointer unchanged on idle cycles.
REQ-025 MODE 1: i_lock high and current owner's i_req high -> owner re-granted, pointer unchanged; owner drops i_req -> normal arbitration same cycle.
REQ-026 MODE 1: multiple requesters are not contention; o_contention never sets.
REQ-027 o_bus_valid = 1 iff at least one i_req bit was high in the sampled cycle.
REQ-028 Idle (no i_req): o_grant = 0, o_owner = 0, o_bus_data = previous value if HOLD_EN = 1, else 0.
REQ-029 Counter saturates at 2^CNT_WIDTH-1; o_contention stays 1 until cleared.
REQ-030 i_clear_err and a new contention in the same cycle: set wins, counter becomes 1.
REQ-031 i_clear_err alone: flag and counter become 0 on the next edge.

Reset
REQ-032 i_rst_n low asynchronously forces all outputs to 0 and the round-robin pointer to 0.
REQ-033 Reset mid-transfer drops the grant immediately; first arbitration after reset starts at source 0.

Structure
REQ-034 A shared package bus_pkg holds MODE_WIRED_OR/MODE_ROUND_ROBIN constants and a popcount function.
REQ-035 Round-robin selection is a separate sub-module rr_arbiter (request, pointer -> one-hot winner, combinational).

Verification
REQ-036 MODE 0, i_req=000001, src0 data=0x5A -> next cycle o_bus_data=0x5A, o_bus_valid=1, o_contention=0.
REQ-037 MODE 0, i_req=000011, src0=0xF0, src1=0x0F -> o_bus_data=0xFF, o_contention=1, count=1; repeat 300 cycles -> count=255.
REQ-038 MODE 1, i_req=101010 held 4 cycles -> o_owner sequence 1,3,5,1.
REQ-039 MODE 1, i_lock=1, src2 owns with i_req=000110 for 3 cycles -> o_owner 2,2,2; src2 drops -> o_owner=1.
REQ-040 HOLD_EN=1, grant src4 data 0x33, then i_req=0 -> o_bus_data stays 0x33, o_bus_valid=0; HOLD_EN=0 -> 0x00.
REQ-041 LANE_MASK slice 5 = 0x0F, src5 data=0xAB -> o_bus_data=0x0B; assert i_rst_n low mid-grant -> all outputs 0 without a clock edge.
